// File: rtl/mono_sample_decimator_if.sv
// -----------------------------------------------------------------------------
// mono_sample_decimator_if
// Groups the sample-side and FIFO-side signals of mono_sample_decimator.
//   master : the producer/consumer environment. It drives enable,
//            mono_sample_valid, mono_sample and fifo_full, and observes the
//            decimated output, drop counter and window position.
//   slave  : the decimator itself, which sees the same signals in the
//            opposite direction.
// Parameters must match those of the decimator instance bound to it.
// -----------------------------------------------------------------------------
interface mono_sample_decimator_if #(
  parameter int SAMPLE_WIDTH   = 24,
  parameter int DECIM_LOG2     = 2,
  parameter int DROP_CNT_WIDTH = 16
);
  localparam int POS_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;

  logic                           enable;
  logic                           mono_sample_valid;
  logic signed [SAMPLE_WIDTH-1:0] mono_sample;
  logic                           fifo_full;
  logic                           dec_sample_valid;
  logic signed [SAMPLE_WIDTH-1:0] dec_sample;
  logic [DROP_CNT_WIDTH-1:0]      drop_count;
  logic [POS_W-1:0]               window_pos;

  modport master (
    output enable, mono_sample_valid, mono_sample, fifo_full,
    input  dec_sample_valid, dec_sample, drop_count, window_pos
  );

  modport slave (
    input  enable, mono_sample_valid, mono_sample, fifo_full,
    output dec_sample_valid, dec_sample, drop_count, window_pos
  );
endinterface

// File: rtl/mono_sample_decimator.sv
// -----------------------------------------------------------------------------
// mono_sample_decimator
// Decimates a signed mono sample stream by R = 2**DECIM_LOG2. Every R accepted
// samples (mono_sample_valid & enable) produce one result, written to a
// downstream FIFO as a one-cycle strobe during the EMIT cycle that follows
// the R-th sample. A result that meets fifo_full is discarded and counted in
// a saturating drop counter.
//
// Build option: define DECIM_PEAK_HOLD_EN to emit the largest-magnitude sample
// of each window (peak hold) instead of the floor mean.
//
// Ports:
//   clk     : single clock, posedge
//   resetn  : asynchronous active-low reset
//   bus     : mono_sample_decimator_if.slave
//             in : enable, mono_sample_valid, mono_sample, fifo_full
//             out: dec_sample_valid (FIFO wr_en), dec_sample (FIFO din),
//                  drop_count, window_pos
// -----------------------------------------------------------------------------
module mono_sample_decimator #(
  parameter int SAMPLE_WIDTH   = 24,
  parameter int DECIM_LOG2     = 2,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  mono_sample_decimator_if.slave      bus
);

  localparam int POS_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int R     = 1 << DECIM_LOG2;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(R - 1);

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t                         state_p0;
  logic [POS_W-1:0]               pos_p0;
  logic signed [SAMPLE_WIDTH-1:0] res_p0;
  logic signed [SAMPLE_WIDTH-1:0] out_p1;
  logic [DROP_CNT_WIDTH-1:0]      drop_p1;

  logic accept;
  logic last;
  logic emit_ok;
  logic emit_drop;

  assign accept    = bus.enable & bus.mono_sample_valid;
  assign last      = (pos_p0 == LAST_POS);
  // The write decision uses fifo_full in the EMIT cycle itself, so wr_en is
  // never raised while the FIFO reports full. enable=0 cancels the result.
  assign emit_ok   = (state_p0 == EMIT) & bus.enable & ~bus.fifo_full;
  assign emit_drop = (state_p0 == EMIT) & bus.enable &  bus.fifo_full;

  function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(
    input logic [DROP_CNT_WIDTH-1:0] c
  );
    return (&c) ? c : c + DROP_CNT_WIDTH'(1);
  endfunction

`ifdef DECIM_PEAK_HOLD_EN
  localparam int WIN_W = SAMPLE_WIDTH;

  // Most-negative input is clamped to the largest positive magnitude so it
  // ties with +max rather than exceeding it.
  function automatic logic [SAMPLE_WIDTH-1:0] magnitude(
    input logic signed [SAMPLE_WIDTH-1:0] s
  );
    if (s == {1'b1, {(SAMPLE_WIDTH-1){1'b0}}})
      return {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    else if (s[SAMPLE_WIDTH-1])
      return $unsigned(-s);
    else
      return $unsigned(s);
  endfunction

  logic signed [WIN_W-1:0]        win_p0;
  logic signed [WIN_W-1:0]        win_next;
  logic signed [SAMPLE_WIDTH-1:0] result_next;

  // Strictly-greater replacement keeps the earliest sample on ties.
  always_comb begin
    win_next = bus.mono_sample;
    if (pos_p0 != '0 && magnitude(bus.mono_sample) <= magnitude(win_p0))
      win_next = win_p0;
    result_next = win_next;
  end
`else
  localparam int WIN_W = SAMPLE_WIDTH + DECIM_LOG2;

  // Arithmetic shift gives floor division; R samples never overflow WIN_W.
  function automatic logic signed [SAMPLE_WIDTH-1:0] mean_of(
    input logic signed [WIN_W-1:0] a
  );
    logic signed [WIN_W-1:0] sh;
    sh = a >>> DECIM_LOG2;
    return sh[SAMPLE_WIDTH-1:0];
  endfunction

  logic signed [WIN_W-1:0]        win_p0;
  logic signed [WIN_W-1:0]        win_next;
  logic signed [SAMPLE_WIDTH-1:0] result_next;

  // win_p0 is zero at window position 0, so a plain add starts each window.
  always_comb begin
    win_next    = win_p0 + WIN_W'(bus.mono_sample);
    result_next = mean_of(win_next);
  end
`endif

  // p0: window collection and result register; p1: output hold and drops
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_p0 <= ACCUM;
      win_p0   <= '0;
      pos_p0   <= '0;
      res_p0   <= '0;
      out_p1   <= '0;
      drop_p1  <= '0;
    end else begin
      if (emit_ok)   out_p1  <= res_p0;
      if (emit_drop) drop_p1 <= sat_inc(drop_p1);

      if (!bus.enable) begin
        state_p0 <= ACCUM;
        win_p0   <= '0;
        pos_p0   <= '0;
      end else if (accept) begin
        if (last) begin
          state_p0 <= EMIT;
          win_p0   <= '0;
          pos_p0   <= '0;
          res_p0   <= result_next;
        end else begin
          state_p0 <= ACCUM;
          win_p0   <= win_next;
          pos_p0   <= pos_p0 + POS_W'(1);
        end
      end else begin
        state_p0 <= ACCUM;
      end
    end
  end

  assign bus.dec_sample_valid = emit_ok;
  // The fresh result is presented with its strobe; otherwise the last
  // written value is held.
  assign bus.dec_sample       = emit_ok ? res_p0 : out_p1;
  assign bus.drop_count       = drop_p1;
  assign bus.window_pos       = pos_p0;

endmodule

// File: tb/tb_mono_sample_decimator.sv
// -----------------------------------------------------------------------------
// tb_mono_sample_decimator
// Directed stimulus for mono_sample_decimator (R = 4, 24-bit samples).
// Expected results are queued with the cycle they must appear in; a monitor
// on the falling edge compares dec_sample_valid every cycle and dec_sample on
// each strobe. A second instance with a 2-bit drop counter shares the stimulus
// to exercise drop counter saturation.
// -----------------------------------------------------------------------------
module tb_mono_sample_decimator;
  localparam int SW = 24;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  mono_sample_decimator_if #(.SAMPLE_WIDTH(SW), .DECIM_LOG2(2), .DROP_CNT_WIDTH(16)) bus ();
  mono_sample_decimator_if #(.SAMPLE_WIDTH(SW), .DECIM_LOG2(2), .DROP_CNT_WIDTH(2))  bus_s ();

  mono_sample_decimator #(.SAMPLE_WIDTH(SW), .DECIM_LOG2(2), .DROP_CNT_WIDTH(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  mono_sample_decimator #(.SAMPLE_WIDTH(SW), .DECIM_LOG2(2), .DROP_CNT_WIDTH(2)) dut_s (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_s)
  );

  assign bus_s.enable            = bus.enable;
  assign bus_s.mono_sample_valid = bus.mono_sample_valid;
  assign bus_s.mono_sample       = bus.mono_sample;
  assign bus_s.fifo_full         = bus.fifo_full;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ncyc  = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int pick(input int mean_v, input int peak_v);
`ifdef DECIM_PEAK_HOLD_EN
    return peak_v;
`else
    return mean_v;
`endif
  endfunction

  // Monitor: strobe must appear exactly in the queued cycle and nowhere else.
  always @(negedge clk) begin
    bit   want;
    exp_t e;
    ncyc++;
    want = (exp_q.size() > 0) && (exp_q[0].cyc == ncyc);
    check("dec_sample_valid", longint'(bus.dec_sample_valid), longint'(want));
    if (want) begin
      e = exp_q.pop_front();
      if (bus.dec_sample_valid)
        check("dec_sample", longint'(bus.dec_sample), longint'(e.val));
    end
  end

  // One valid cycle; when push is set the strobe is expected at the next
  // falling edge after the accepting clock edge.
  task automatic send(input int v, input bit push, input int ev);
    bus.mono_sample       = SW'(v);
    bus.mono_sample_valid = 1'b1;
    @(posedge clk);
    if (push) exp_q.push_back('{val: ev, cyc: ncyc + 1});
    #1 bus.mono_sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.enable            = 1'b1;
    bus.mono_sample_valid = 1'b0;
    bus.mono_sample       = '0;
    bus.fifo_full         = 1'b0;

    // Reset state
    #1 resetn = 1'b0;
    #2;
    check("reset_valid", longint'(bus.dec_sample_valid), 0);
    check("reset_dec_sample", longint'(bus.dec_sample), 0);
    check("reset_drop_count", longint'(bus.drop_count), 0);
    check("reset_window_pos", longint'(bus.window_pos), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    idle(1);

    // Basic mean: (100+200+300+400)/4
    send(100, 0, 0); send(200, 0, 0); send(300, 0, 0);
    send(400, 1, pick(250, 400));
    idle(2);

    // Floor toward minus infinity: -3/4 -> -1
    send(-1, 0, 0); send(-1, 0, 0); send(-1, 0, 0);
    send(0, 1, pick(-1, -1));
    idle(2);

    // Full-scale positive, no overflow
    for (int i = 0; i < 4; i++) send(8388607, i == 3, pick(8388607, 8388607));
    idle(2);

    // Back-to-back 1..8: second window starts during EMIT
    for (int i = 1; i <= 8; i++)
      send(i, (i % 4) == 0, (i == 4) ? pick(2, 4) : pick(6, 8));
    idle(2);

    // Idle cycles inside a window do not disturb it
    send(4, 0, 0); idle(3);
    send(8, 0, 0);
    check("window_pos_2", longint'(bus.window_pos), 2);
    idle(1);
    send(12, 0, 0);
    check("window_pos_3", longint'(bus.window_pos), 3);
    idle(2);
    send(16, 1, pick(10, 16));
    idle(2);
    check("dec_sample_hold", longint'(bus.dec_sample), longint'(pick(10, 16)));

    // fifo_full during EMIT: no strobe, one drop, output held
    bus.fifo_full = 1'b1;
    send(1, 0, 0); send(2, 0, 0); send(3, 0, 0); send(4, 0, 0);
    idle(1);
    check("drop_count_1", longint'(bus.drop_count), 1);
    check("drop_count_s_1", longint'(bus_s.drop_count), 1);
    check("dec_sample_hold_drop", longint'(bus.dec_sample), longint'(pick(10, 16)));

    // Four more drops: 2-bit counter saturates at 3
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) send(k + 1, 0, 0);
      idle(1);
    end
    check("drop_count_5", longint'(bus.drop_count), 5);
    check("drop_count_s_sat", longint'(bus_s.drop_count), 3);
    bus.fifo_full = 1'b0;
    idle(1);

    // enable=0 flushes a partial window and beats a simultaneous valid
    send(3, 0, 0); send(5, 0, 0);
    check("window_pos_pre_flush", longint'(bus.window_pos), 2);
    bus.enable            = 1'b0;
    bus.mono_sample       = SW'(100);
    bus.mono_sample_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.enable            = 1'b1;
    bus.mono_sample_valid = 1'b0;
    check("window_pos_flush", longint'(bus.window_pos), 0);
    send(8, 0, 0); send(8, 0, 0); send(8, 0, 0);
    send(8, 1, pick(8, 8));
    idle(2);

    // enable=0 during EMIT cancels the result: no strobe, no drop
    send(1, 0, 0); send(1, 0, 0); send(1, 0, 0); send(1, 0, 0);
    bus.enable    = 1'b0;
    bus.fifo_full = 1'b1;
    @(posedge clk);
    #1;
    bus.enable    = 1'b1;
    bus.fifo_full = 1'b0;
    check("drop_count_cancel", longint'(bus.drop_count), 5);
    idle(1);

    // Reset mid-window discards the partial window
    send(7, 0, 0); send(7, 0, 0); send(7, 0, 0);
    resetn = 1'b0;
    #2;
    check("window_pos_reset", longint'(bus.window_pos), 0);
    check("drop_count_reset", longint'(bus.drop_count), 0);
    check("dec_sample_reset", longint'(bus.dec_sample), 0);
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < 4; i++) send(-4, i == 3, pick(-4, -4));
    idle(2);

    // Peak-mode vectors (mean results when the option is off)
    send(5, 0, 0); send(-9, 0, 0); send(9, 0, 0);
    send(-3, 1, pick(0, -9));
    idle(2);
    send(-8388608, 0, 0); send(8388607, 0, 0); send(0, 0, 0);
    send(0, 1, pick(-1, -8388608));
    idle(3);

    check("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
